// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter.
//   state_e        : FSM encoding (IDLE=0, GATE=1, LATCH=2)
//   GATE_*_DEF     : default gate window lengths in clk cycles (100 MHz clock)
//   GATE_CNT_W     : gate counter width, covers GATE_LONG_DEF-1
//   bcd_inc4()     : 4-digit BCD increment, wraps 9999 -> 0000 (callers saturate)
package freq_meter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGate  = 2'd1,
        StLatch = 2'd2
    } state_e;

    localparam int unsigned GATE_LONG_DEF  = 100_000_000;
    localparam int unsigned GATE_SHORT_DEF = 1_000_000;
    localparam int unsigned GATE_CNT_W     = 27;

    function automatic logic [15:0] bcd_inc4(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD event counter with synchronous clear and saturation.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of count and sat (has priority over inc)
//   inc        : count one event
//   value      : current count, 4 BCD digits, [15:12] most significant
//   sat        : set when an event arrives while the count is already 9999
module bcd_counter4
    import freq_meter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] value,
    output logic        sat
);

    logic [15:0] cnt_q, cnt_d;
    logic        sat_q, sat_d;

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr) begin
            cnt_d = 16'h0000;
            sat_d = 1'b0;
        end else if (inc) begin
            if (cnt_q == 16'h9999) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = bcd_inc4(cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'h0000;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign value = cnt_q;
    assign sat   = sat_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of sig_in during a fixed gate window
// and reports the count as 4 BCD digits.
//   clk, rst_n : 100 MHz clock, asynchronous active-low reset
//   sig_in     : asynchronous input under measurement (< clk/4)
//   start      : one-cycle request for a single measurement (ignored while busy)
//   cont       : continuous mode, re-arms after every result
//   range      : 0 = GATE_LONG window (Hz), 1 = GATE_SHORT window (x100 Hz)
//   bcd, ovf   : last latched result and its saturation flag
//   valid      : one-cycle pulse coincident with bcd/ovf updating
//   busy       : gate window open or result being latched
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_LONG  = GATE_LONG_DEF,
    parameter int unsigned GATE_SHORT = GATE_SHORT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_in,
    input  logic        start,
    input  logic        cont,
    input  logic        range,
    output logic [15:0] bcd,
    output logic        valid,
    output logic        ovf,
    output logic        busy
);

    localparam logic [GATE_CNT_W-1:0] LAST_LONG  = GATE_CNT_W'(GATE_LONG - 1);
    localparam logic [GATE_CNT_W-1:0] LAST_SHORT = GATE_CNT_W'(GATE_SHORT - 1);

    // Two-flop synchroniser plus history flop for rising-edge detection.
    logic sync1_q, sync2_q, hist_q;
    logic edge_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign edge_det = sync2_q & ~hist_q;

    state_e                  state_q, state_d;
    logic [GATE_CNT_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic                    range_q, range_d;
    logic [15:0]             bcd_q, bcd_d;
    logic                    ovf_q, ovf_d;
    logic                    valid_q, valid_d;
    logic                    cnt_clr, cnt_inc;
    logic [15:0]             cnt_value;
    logic                    cnt_sat;
    logic [GATE_CNT_W-1:0]   gate_last;

    // Window length is fixed by the range sampled when the window opened.
    assign gate_last = range_q ? LAST_SHORT : LAST_LONG;

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        range_d    = range_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start || cont) begin
                    state_d    = StGate;
                    gate_cnt_d = '0;
                    range_d    = range;
                    cnt_clr    = 1'b1;
                end
            end
            StGate: begin
                cnt_inc    = edge_det;
                gate_cnt_d = gate_cnt_q + 1'b1;
                if (gate_cnt_q == gate_last) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                // Result registers and valid update together on the next edge.
                bcd_d   = cnt_value;
                ovf_d   = cnt_sat;
                valid_d = 1'b1;
                if (cont) begin
                    state_d    = StGate;
                    gate_cnt_d = '0;
                    range_d    = range;
                    cnt_clr    = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gate_cnt_q <= '0;
            range_q    <= 1'b0;
            bcd_q      <= 16'h0000;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            range_q    <= range_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    bcd_counter4 u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .value (cnt_value),
        .sat   (cnt_sat)
    );

    assign bcd   = bcd_q;
    assign ovf   = ovf_q;
    assign valid = valid_q;
    assign busy  = (state_q != StIdle);

endmodule
